// File: rtl/guess_controller.sv
// Hangman round sequencer: latches the word/mask at round start, scores letter
// guesses over a valid/ready handshake, and reports win/loss to the level selector.
module guess_controller #(
  parameter int NUM_SLOTS = 6,
  parameter int LETTER_W  = 5,
  parameter int MAX_LIVES = 6,
  parameter int LIVES_W   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_game,
  input  logic                          guess_valid,
  input  logic [LETTER_W-1:0]           guess_letter,
  output logic                          guess_ready,
  input  logic [NUM_SLOTS*LETTER_W-1:0] word,
  input  logic [25:0]                   mask,
  output logic                          start_game,
  output logic                          lost_game,
  output logic [NUM_SLOTS-1:0]          revealed,
  output logic [25:0]                   guessed,
  output logic [LIVES_W-1:0]            lives_left,
  output logic                          repeat_guess,
  output logic                          round_won,
  output logic                          round_lost,
  output logic [2:0]                    state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    CHECK   = 3'd3,
    RESOLVE = 3'd4,
    WIN     = 3'd5,
    LOSE    = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [NUM_SLOTS*LETTER_W-1:0] word_q;
  logic [25:0]                   mask_q;
  logic [LETTER_W-1:0]           letter_q;
  logic [NUM_SLOTS-1:0]          revealed_q;
  logic [25:0]                   guessed_q;
  logic [LIVES_W-1:0]            lives_q;
  logic                          ready_q, repeat_q, won_q, lost_q;

  logic                 letter_ok, letter_seen, letter_hit;
  logic [4:0]           letter_idx;
  logic [NUM_SLOTS-1:0] slot_match, blank_slot;

  always_comb begin
    letter_ok   = (letter_q != '0) && (letter_q <= LETTER_W'(26));
    letter_idx  = 5'(letter_q - LETTER_W'(1));
    letter_seen = guessed_q[letter_idx];
    letter_hit  = ~mask_q[letter_idx];
    slot_match  = '0;
    blank_slot  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_match[i] = (word_q[LETTER_W*i +: LETTER_W] == letter_q);
      blank_slot[i] = (word[LETTER_W*i +: LETTER_W] == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_game) state_d = LOAD;
      LOAD:    state_d = PLAY;
      PLAY:    if (guess_valid) state_d = CHECK;
      CHECK:   state_d = RESOLVE;
      RESOLVE: begin
        if (&revealed_q)          state_d = WIN;
        else if (lives_q == '0)   state_d = LOSE;
        else                      state_d = PLAY;
      end
      WIN, LOSE: if (new_game) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      mask_q     <= '0;
      letter_q   <= '0;
      revealed_q <= '0;
      guessed_q  <= '0;
      lives_q    <= LIVES_W'(MAX_LIVES);
      ready_q    <= 1'b0;
      repeat_q   <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == PLAY);
      won_q    <= (state_d == WIN);
      lost_q   <= (state_d == LOSE);
      repeat_q <= 1'b0;
      case (state_q)
        LOAD: begin
          word_q     <= word;
          mask_q     <= mask;
          guessed_q  <= '0;
          lives_q    <= LIVES_W'(MAX_LIVES);
          revealed_q <= blank_slot;
        end
        PLAY: if (guess_valid) letter_q <= guess_letter;
        CHECK: begin
          if (!letter_ok || letter_seen) begin
            repeat_q <= 1'b1;
          end else begin
            guessed_q[letter_idx] <= 1'b1;
            if (letter_hit)          revealed_q <= revealed_q | slot_match;
            else if (lives_q != '0)  lives_q    <= lives_q - LIVES_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // start_game is gated by new_game so it shares the cycle with lost_game in LOSE
  assign start_game   = new_game && (state_q == WIN || state_q == LOSE);
  assign guess_ready  = ready_q;
  assign lost_game    = lost_q;
  assign round_lost   = lost_q;
  assign round_won    = won_q;
  assign repeat_guess = repeat_q;
  assign revealed     = revealed_q;
  assign guessed      = guessed_q;
  assign lives_left   = lives_q;
  assign state        = state_q;

endmodule

// File: tb/tb_guess_controller.sv
// Self-checking bench for guess_controller: hand-derived vector tables for the
// scripted rounds, then random rounds scored against a set-based game model.
module tb_guess_controller;
  localparam int NS = 6, LW = 5, ML = 6, LVW = 3;

  logic           clk = 1'b0;
  logic           reset, new_game, guess_valid;
  logic [LW-1:0]  guess_letter;
  logic           guess_ready;
  logic [NS*LW-1:0] word;
  logic [25:0]    mask;
  logic           start_game, lost_game, repeat_guess, round_won, round_lost;
  logic [NS-1:0]  revealed;
  logic [25:0]    guessed;
  logic [LVW-1:0] lives_left;
  logic [2:0]     state;

  guess_controller #(.NUM_SLOTS(NS), .LETTER_W(LW), .MAX_LIVES(ML), .LIVES_W(LVW)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .guess_valid(guess_valid),
    .guess_letter(guess_letter), .guess_ready(guess_ready), .word(word), .mask(mask),
    .start_game(start_game), .lost_game(lost_game), .revealed(revealed), .guessed(guessed),
    .lives_left(lives_left), .repeat_guess(repeat_guess), .round_won(round_won),
    .round_lost(round_lost), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, starts = 0;
  always @(negedge clk) if (start_game === 1'b1) starts++;

  // Game model: word/mask as latched at round start and the set of guessed letters.
  int        m_word[NS];
  logic [25:0] m_mask;
  bit [26:0] m_g;
  int        m_st;

  function automatic logic [NS-1:0] m_rev();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++)
      r[i] = (m_word[i] == 0) || (m_word[i] <= 26 && m_g[m_word[i]] && !m_mask[m_word[i]-1]);
    return r;
  endfunction

  function automatic int m_lives();
    int misses = 0;
    for (int c = 1; c <= 26; c++) if (m_g[c] && m_mask[c-1]) misses++;
    return (misses >= ML) ? 0 : ML - misses;
  endfunction

  function automatic logic [25:0] m_guessed();
    logic [25:0] g;
    for (int c = 1; c <= 26; c++) g[c-1] = m_g[c];
    return g;
  endfunction

  function automatic int m_next_state();
    if (&m_rev()) return 5;
    if (m_lives() == 0) return 6;
    return 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_round(input logic [NS*LW-1:0] w, input logic [25:0] mk);
    @(posedge clk); #1;
    word = w; mask = mk; new_game = 1'b1;
    @(negedge clk);
    check("start_game_on_new_game", 32'(start_game), 32'(m_st == 5 || m_st == 6));
    check("lost_game_with_start", 32'(lost_game), 32'(m_st == 6));
    @(posedge clk); #1;
    new_game = 1'b0;
    for (int i = 0; i < NS; i++) m_word[i] = int'(w[LW*i +: LW]);
    m_mask = mk; m_g = '0; m_st = 1;
    @(negedge clk);
    check("load_state", 32'(state), 32'd1);
    check("load_lost_dropped", 32'(lost_game), 32'd0);
    check("load_start_low", 32'(start_game), 32'd0);
    @(negedge clk);
    m_st = 2;
    check("play_state", 32'(state), 32'd2);
    check("play_ready", 32'(guess_ready), 32'd1);
    check("play_revealed", 32'(revealed), 32'(m_rev()));
    check("play_guessed", 32'(guessed), 32'd0);
    check("play_lives", 32'(lives_left), 32'(ML));
  endtask

  task automatic wait_ready();
    int k = 0;
    while (k < 10) begin
      @(negedge clk);
      if (guess_ready === 1'b1) break;
      k++;
    end
    check("ready_wait", 32'(k < 10), 32'd1);
  endtask

  task automatic do_guess(input int c, output logic rep_seen);
    bit rep;
    wait_ready();
    guess_valid = 1'b1; guess_letter = LW'(c);
    @(posedge clk); #1;
    guess_valid = 1'b0; guess_letter = LW'($urandom);
    rep = (c == 0) || (c > 26) || m_g[c];
    if (!rep) m_g[c] = 1'b1;
    @(negedge clk);
    check("check_state", 32'(state), 32'd3);
    check("check_ready_low", 32'(guess_ready), 32'd0);
    @(negedge clk);
    rep_seen = repeat_guess;
    check("resolve_state", 32'(state), 32'd4);
    check("repeat_guess", 32'(repeat_guess), 32'(rep));
    check("lives_left", 32'(lives_left), 32'(m_lives()));
    check("revealed", 32'(revealed), 32'(m_rev()));
    check("guessed", 32'(guessed), 32'(m_guessed()));
    @(negedge clk);
    m_st = m_next_state();
    check("post_state", 32'(state), 32'(m_st));
    check("post_ready", 32'(guess_ready), 32'(m_st == 2));
    check("round_won", 32'(round_won), 32'(m_st == 5));
    check("round_lost", 32'(round_lost), 32'(m_st == 6));
    check("lost_game", 32'(lost_game), 32'(m_st == 6));
    check("repeat_cleared", 32'(repeat_guess), 32'd0);
  endtask

  typedef struct {
    int          letter;
    logic        rep;
    int          lives;
    logic [5:0]  rev;
    int          st;
  } vec_t;

  vec_t tab1[9];
  vec_t tab2[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic rep_seen;
    logic [NS*LW-1:0] w1, w2, wr;
    logic [25:0] mk1, mk2, mkr;
    int start_snap, guesses;

    tab1[0] = '{5,  1'b0, 6, 6'b100100, 2};
    tab1[1] = '{26, 1'b0, 5, 6'b100100, 2};
    tab1[2] = '{26, 1'b1, 5, 6'b100100, 2};
    tab1[3] = '{0,  1'b1, 5, 6'b100100, 2};
    tab1[4] = '{27, 1'b1, 5, 6'b100100, 2};
    tab1[5] = '{14, 1'b0, 5, 6'b110100, 2};
    tab1[6] = '{3,  1'b0, 5, 6'b111100, 2};
    tab1[7] = '{12, 1'b0, 5, 6'b111110, 2};
    tab1[8] = '{19, 1'b0, 5, 6'b111111, 5};
    tab2[0] = '{1, 1'b0, 5, 6'b100100, 2};
    tab2[1] = '{2, 1'b0, 4, 6'b100100, 2};
    tab2[2] = '{4, 1'b0, 3, 6'b100100, 2};
    tab2[3] = '{6, 1'b0, 2, 6'b100100, 2};
    tab2[4] = '{7, 1'b0, 1, 6'b100100, 2};
    tab2[5] = '{8, 1'b0, 0, 6'b100100, 6};

    w1  = {5'd5, 5'd14, 5'd3, 5'd5, 5'd12, 5'd19};
    mk1 = ~(26'(1) << 4 | 26'(1) << 13 | 26'(1) << 2 | 26'(1) << 11 | 26'(1) << 18);
    w2  = {5'd0, 5'd5, 5'd14, 5'd0, 5'd3, 5'd19};
    mk2 = ~(26'(1) << 4 | 26'(1) << 13 | 26'(1) << 2 | 26'(1) << 18);

    reset = 1'b1; new_game = 1'b0; guess_valid = 1'b0; guess_letter = '0;
    word = '0; mask = '1; m_st = 0; m_g = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_lives", 32'(lives_left), 32'(ML));
    check("reset_revealed", 32'(revealed), 32'd0);
    check("reset_guessed", 32'(guessed), 32'd0);
    check("reset_ready", 32'(guess_ready), 32'd0);
    check("reset_start", 32'(start_game), 32'd0);

    // Round 1: scripted win from IDLE (no start_game expected).
    start_round(w1, mk1);
    for (int i = 0; i < 9; i++) begin
      do_guess(tab1[i].letter, rep_seen);
      check($sformatf("tab1[%0d]_repeat", i), 32'(rep_seen), 32'(tab1[i].rep));
      check($sformatf("tab1[%0d]_lives", i), 32'(lives_left), 32'(tab1[i].lives));
      check($sformatf("tab1[%0d]_revealed", i), 32'(revealed), 32'(tab1[i].rev));
      check($sformatf("tab1[%0d]_state", i), 32'(state), 32'(tab1[i].st));
    end

    // Round 2: scripted loss; word input scrambled mid-round must be ignored.
    start_round(w2, mk2);
    word = {NS{5'd1}}; mask = '0;
    for (int i = 0; i < 6; i++) begin
      do_guess(tab2[i].letter, rep_seen);
      check($sformatf("tab2[%0d]_lives", i), 32'(lives_left), 32'(tab2[i].lives));
      check($sformatf("tab2[%0d]_revealed", i), 32'(revealed), 32'(tab2[i].rev));
      check($sformatf("tab2[%0d]_state", i), 32'(state), 32'(tab2[i].st));
    end

    // Round 3: start from LOSE, then reset during a CHECK cycle.
    start_round(w1, mk1);
    do_guess(5, rep_seen);
    wait_ready();
    start_snap = starts;
    guess_valid = 1'b1; guess_letter = LW'(26);
    @(posedge clk); #1;
    guess_valid = 1'b0;
    check("pre_reset_in_check", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("midreset_state", 32'(state), 32'd0);
    check("midreset_lives", 32'(lives_left), 32'(ML));
    check("midreset_revealed", 32'(revealed), 32'd0);
    check("midreset_guessed", 32'(guessed), 32'd0);
    check("midreset_ready", 32'(guess_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_no_start", 32'(starts), 32'(start_snap));
    check("midreset_idle_held", 32'(state), 32'd0);
    m_st = 0;

    // Random rounds against the model.
    for (int r = 0; r < 8; r++) begin
      mkr = '1;
      for (int i = 0; i < NS; i++) begin
        int code;
        code = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 26));
        wr[LW*i +: LW] = LW'(code);
        if (code != 0) mkr[code-1] = 1'b0;
      end
      start_round(wr, mkr);
      guesses = 0;
      while (m_st == 2 && guesses < 300) begin
        do_guess(int'($urandom_range(0, 28)), rep_seen);
        guesses++;
      end
      check("random_round_ended", 32'(m_st == 5 || m_st == 6), 32'd1);
      if (m_st != 5 && m_st != 6) break;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/guess_controller.md
Name: guess_controller

Overview:
- Sequences one Hangman round against the word/mask pair produced by the level selector.
- Accepts letter guesses over a valid/ready handshake and tracks which letters have already been guessed, which word slots are revealed, and how many lives remain.
- Detects win/loss and drives start_game/lost_game back to the level selector to advance or fail the level.
- Sits between the keyboard/guess-entry logic and the level selector; display logic consumes its status outputs.

Parameters:
- NUM_SLOTS, 6, letter slots in word.
- LETTER_W, 5, bits per letter code.
- MAX_LIVES, 6, wrong guesses allowed per round.
- LIVES_W, 3, width of lives counter; must hold MAX_LIVES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  request to begin the next round (level).
- guess_valid  in  1  guess letter presented.
- guess_letter  in  LETTER_W  letter code, 1=A..26=Z.
- guess_ready  out  1  controller can accept a guess.
- word  in  NUM_SLOTS*LETTER_W  current word; slot i = word[LETTER_W*i +: LETTER_W]; code 0 = blank slot.
- mask  in  26  bit (c-1)=0 means letter c occurs in word.
- start_game  out  1  one-cycle pulse advancing the level selector.
- lost_game  out  1  high while round lost.
- revealed  out  NUM_SLOTS  bit i=1 when slot i is shown.
- guessed  out  26  bit (c-1)=1 once letter c has been guessed.
- lives_left  out  LIVES_W  remaining lives.
- repeat_guess  out  1  one-cycle pulse: accepted guess was a repeat or invalid.
- round_won  out  1  high in WIN.
- round_lost  out  1  high in LOSE.
- state  out  3  FSM state for debug/display.

Behaviour:
- Reset (async, any state): state=IDLE; revealed=0, guessed=0, lives_left=MAX_LIVES; all pulses and status outputs 0; latched word cleared.
- State encodings: IDLE=0, LOAD=1, PLAY=2, CHECK=3, RESOLVE=4, WIN=5, LOSE=6.
- IDLE: wait for new_game, then go to LOAD. No start_game pulse on the first round after reset; the level selector is already at its first level.
- WIN/LOSE: outputs held. On new_game, assert start_game for exactly that cycle and go to LOAD.
  - In LOSE, lost_game stays high through that cycle so the level selector samples it.
  - lost_game drops on entry to LOAD.
- LOAD (1 cycle):
  - Latch word and mask into internal registers; the game uses only latched copies, so input changes mid-round are ignored.
  - guessed=0, lives_left=MAX_LIVES.
  - revealed[i]=1 for every blank slot (code 0), else 0.
  - Next state is PLAY.
- PLAY: guess_ready=1 (only here). Handshake completes when guess_valid & guess_ready; the letter is captured and the FSM goes to CHECK. new_game is ignored in PLAY.
- CHECK (1 cycle), for captured letter c:
  - c==0 or c>26: repeat_guess pulse, no other change.
  - guessed[c-1]==1: repeat_guess pulse, no life lost.
  - Hit (latched mask[c-1]==0): set guessed[c-1] and OR in every slot whose code equals c.
  - Miss: set guessed[c-1] and decrement lives_left. Saturate at 0, never wrap.
- RESOLVE (1 cycle), evaluated on updated values:
  - If &revealed, go to WIN.
  - Else if lives_left==0, go to LOSE.
  - Else go to PLAY.
  - Win takes priority if both conditions are true.
- Guess-to-ready latency: accept at edge N; CHECK at N+1; RESOLVE at N+2; guess_ready high again at N+3 if still playing.
- round_won = (state==WIN); round_lost = lost_game = (state==LOSE). All outputs are registered.
- Reset mid-round aborts immediately to IDLE with the reset values above; no start_game is issued.

Test Plan:
- Reset, then release -> state=0, lives_left=6, revealed=0, guessed=0, guess_ready=0, start_game=0.
- Word {5,14,3,5,12,19} (slot5..slot0), mask with bits 4,13,2,11,18 low; new_game, then guess 5 -> guessed[4]=1, revealed=6'b100100, lives_left=6, guess_ready returns 3 cycles after accept.
- Guess 26 -> lives_left=5. Guess 26 again -> repeat_guess pulses once, lives_left=5. Guess 0 and 27 -> repeat_guess each time, no other change.
- Guess 14, 3, 12, 19 -> revealed=6'b111111, state=WIN, round_won=1, guess_ready=0. Then new_game -> start_game high exactly 1 cycle, lost_game=0, state=LOAD, then PLAY with revealed reset.
- Six distinct misses (1, 2, 4, 6, 7, 8) -> lives_left 6→0, state=LOSE, lost_game=1. Then new_game -> start_game and lost_game both high in the same cycle, lost_game=0 in the next cycle.
- Assert reset during CHECK -> immediate state=IDLE, lives_left=6, start_game never pulses. A word input change mid-PLAY has no effect on hits or reveals.
